// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences the IR, PC, register file and data
// memory strobes and drives the datapath mux/ALU selects.
// Optional macro MC_CONTROL_PERFCNT_EN adds retired-instruction and cycle counters.
module mc_control #(
    parameter int unsigned ALUOP_W         = 3,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               ir_write,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               pc_src,
    output logic               gr_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               dmem_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal,
    output logic [3:0]         state
`ifdef MC_CONTROL_PERFCNT_EN
    ,
    output logic [31:0]        retired,
    output logic [31:0]        cycles
`endif
);

    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] AluSlt = ALUOP_W'(4);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StWbR     = 4'd3,
        StExecI   = 4'd4,
        StWbI     = 4'd5,
        StMemAddr = 4'd6,
        StMemRd   = 4'd7,
        StWbMem   = 4'd8,
        StMemWr   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StIllegal = 4'd12
    } state_e;

    state_e state_q, state_d;

    assign state = state_q;

    // State register with synchronous reset back to fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; reset overrides everything so an aborted
    // instruction never issues a partial write.
    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 1'b0;
        gr_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        dmem_write = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = AluAdd;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (reset) begin
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    ir_write  = 1'b1;
                    pc_inc    = 1'b1;
                    alu_src_b = 2'd1;
                    state_d   = StDecode;
                end
                StDecode: begin
                    // ALU precomputes the branch target while opcode decodes.
                    alu_src_b = 2'd2;
                    case (opcode)
                        6'h00:        state_d = StExecR;
                        6'h08, 6'h0D: state_d = StExecI;
                        6'h23, 6'h2B: state_d = StMemAddr;
                        6'h04:        state_d = StBranch;
                        6'h02:        state_d = StJump;
                        default:      state_d = StIllegal;
                    endcase
                end
                StExecR: begin
                    alu_src_a = 1'b1;
                    state_d   = StWbR;
                    case (funct)
                        6'h20:   alu_op = AluAdd;
                        6'h22:   alu_op = AluSub;
                        6'h24:   alu_op = AluAnd;
                        6'h25:   alu_op = AluOr;
                        6'h2A:   alu_op = AluSlt;
                        default: state_d = StIllegal;
                    endcase
                end
                StWbR: begin
                    gr_write   = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StExecI: begin
                    alu_src_a = 1'b1;
                    // IR still holds the opcode: addi sign-extends, ori zero-extends.
                    if (opcode == 6'h0D) begin
                        alu_src_b = 2'd3;
                        alu_op    = AluOr;
                    end else begin
                        alu_src_b = 2'd2;
                    end
                    state_d = StWbI;
                end
                StWbI: begin
                    gr_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StMemAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    state_d   = (opcode == 6'h2B) ? StMemWr : StMemRd;
                end
                StMemRd: begin
                    state_d = StWbMem;
                end
                StWbMem: begin
                    gr_write   = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StMemWr: begin
                    dmem_write = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StBranch: begin
                    alu_src_a  = 1'b1;
                    alu_op     = AluSub;
                    pc_src     = 1'b1;
                    pc_load    = zero;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StJump: begin
                    pc_load    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
                StIllegal: begin
                    illegal = 1'b1;
                    if (HALT_ON_ILLEGAL) begin
                        state_d = StIllegal;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

`ifdef MC_CONTROL_PERFCNT_EN
    logic [31:0] retired_q, cycles_q;

    assign retired = retired_q;
    assign cycles  = cycles_q;

    // Free-running cycle count and retired-instruction count, both wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= 32'd0;
            cycles_q  <= 32'd0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (instr_done) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed and random instruction streams
// checked cycle by cycle against an instruction-level timing model.
module tb_mc_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ir_write, pc_inc, pc_load, pc_src, gr_write, reg_dst, mem_to_reg;
    logic       dmem_write, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
`ifdef MC_CONTROL_PERFCNT_EN
    logic [31:0] retired, cycles;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .gr_write   (gr_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .dmem_write (dmem_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
`ifdef MC_CONTROL_PERFCNT_EN
        ,
        .retired    (retired),
        .cycles     (cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction latency in cycles; 0 marks an opcode that never completes.
    function automatic int lat_of(input logic [5:0] op);
        case (op)
            6'h00, 6'h08, 6'h0D, 6'h2B: return 4;
            6'h23:                      return 5;
            6'h04, 6'h02:               return 3;
            default:                    return 0;
        endcase
    endfunction

    function automatic logic [31:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 32'd1;
            6'h24:   return 32'd2;
            6'h25:   return 32'd3;
            6'h2A:   return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk_strobes_off(input string tag);
        chk({tag, ".ir_write"}, 32'(ir_write), 0);
        chk({tag, ".pc_inc"}, 32'(pc_inc), 0);
        chk({tag, ".pc_load"}, 32'(pc_load), 0);
        chk({tag, ".gr_write"}, 32'(gr_write), 0);
        chk({tag, ".dmem_write"}, 32'(dmem_write), 0);
        chk({tag, ".instr_done"}, 32'(instr_done), 0);
    endtask

    // Check one cycle of an instruction against what the ISA rules demand.
    task automatic chk_cycle(input int c, input int lat, input logic [5:0] op,
                             input logic [5:0] fn, input logic z);
        logic last;
        logic wr_reg;
        last   = (c == lat);
        wr_reg = (op == 6'h00) || (op == 6'h08) || (op == 6'h0D) || (op == 6'h23);
        chk("ir_write", 32'(ir_write), 32'(c == 1));
        chk("pc_inc", 32'(pc_inc), 32'(c == 1));
        chk("instr_done", 32'(instr_done), 32'(last));
        chk("gr_write", 32'(gr_write), 32'(last && wr_reg));
        chk("dmem_write", 32'(dmem_write), 32'(last && op == 6'h2B));
        chk("pc_load", 32'(pc_load), 32'(last && (op == 6'h02 || (op == 6'h04 && z))));
        chk("illegal", 32'(illegal), 0);
        if (c == 1) begin
            chk("fetch.alu_src_a", 32'(alu_src_a), 0);
            chk("fetch.alu_src_b", 32'(alu_src_b), 1);
            chk("fetch.alu_op", 32'(alu_op), 0);
        end
        if (c == 2) begin
            chk("decode.alu_src_a", 32'(alu_src_a), 0);
            chk("decode.alu_src_b", 32'(alu_src_b), 2);
            chk("decode.alu_op", 32'(alu_op), 0);
        end
        if (c == 3 && op != 6'h02) begin
            chk("exec.alu_src_a", 32'(alu_src_a), 1);
            case (op)
                6'h00: begin
                    chk("execr.alu_src_b", 32'(alu_src_b), 0);
                    chk("execr.alu_op", 32'(alu_op), r_alu(fn));
                end
                6'h0D: begin
                    chk("ori.alu_src_b", 32'(alu_src_b), 3);
                    chk("ori.alu_op", 32'(alu_op), 3);
                end
                6'h04: begin
                    chk("beq.alu_src_b", 32'(alu_src_b), 0);
                    chk("beq.alu_op", 32'(alu_op), 1);
                end
                default: begin
                    chk("addr.alu_src_b", 32'(alu_src_b), 2);
                    chk("addr.alu_op", 32'(alu_op), 0);
                end
            endcase
        end
        if (last && wr_reg) begin
            chk("wb.reg_dst", 32'(reg_dst), 32'(op == 6'h00));
            chk("wb.mem_to_reg", 32'(mem_to_reg), 32'(op == 6'h23));
        end
        if (last && (op == 6'h04 || op == 6'h02)) begin
            chk("pc_src", 32'(pc_src), 32'(op == 6'h04));
        end
    endtask

    // Run one legal instruction from FETCH; returns at a negedge back in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int lat;
        lat    = lat_of(op);
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int c = 1; c <= lat; c++) begin
            #1;
            chk_cycle(c, lat, op, fn, z);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        ops = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        reset  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h20;
        zero   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_strobes_off("reset");
            chk("reset.illegal", 32'(illegal), 0);
            chk("reset.alu_src_b", 32'(alu_src_b), 0);
        end
        reset = 1'b0;

        // Directed: sub, lw, sw, beq taken and not taken, j, addi, ori.
        run_instr(6'h00, 6'h22, 1'b0);
        run_instr(6'h23, 6'h00, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b1);
        run_instr(6'h04, 6'h00, 1'b1);
        run_instr(6'h04, 6'h00, 1'b0);
        run_instr(6'h02, 6'h00, 1'b1);
        run_instr(6'h08, 6'h00, 1'b0);
        run_instr(6'h0D, 6'h00, 1'b0);

        // Random legal instruction stream.
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 6)];
            fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end

        // Illegal opcode parks the FSM until reset.
        opcode = 6'h3F;
        #1;
        chk("ill.fetch.ir_write", 32'(ir_write), 1);
        @(negedge clk);
        #1;
        chk("ill.decode.illegal", 32'(illegal), 0);
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("ill.illegal", 32'(illegal), 1);
            chk_strobes_off("ill");
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("ill.reset.illegal", 32'(illegal), 0);
        chk_strobes_off("ill.reset");
        @(negedge clk);
        reset = 1'b0;
        run_instr(6'h00, 6'h2A, 1'b0);

        // Reset during MEM_ADDR of a store aborts it without a write.
        opcode = 6'h2B;
        #1;
        chk_cycle(1, 4, 6'h2B, 6'h00, 1'b0);
        @(negedge clk);
        #1;
        chk_cycle(2, 4, 6'h2B, 6'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_strobes_off("swabort.reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("swabort.fetch.ir_write", 32'(ir_write), 1);
        chk("swabort.fetch.dmem_write", 32'(dmem_write), 0);
        run_instr(6'h0D, 6'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
